// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: issues one valid/ready request at a time to the ALU operand bus,
// waits out the command latency and returns the captured RES/flags on a valid/ready port.
module alu_cmd_issuer #(
  parameter int WIDTH    = 8,
  parameter int CMD_W    = 4,
  parameter int BASE_LAT = 1,
  parameter int MUL_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_mode,
  input  logic [CMD_W-1:0]   req_cmd,
  input  logic [1:0]         req_inpv,
  input  logic               req_cin,
  input  logic [WIDTH-1:0]   req_opa,
  input  logic [WIDTH-1:0]   req_opb,
  output logic               alu_ce,
  output logic [1:0]         alu_inpv,
  output logic               alu_mode,
  output logic [CMD_W-1:0]   alu_cmd,
  output logic               alu_cin,
  output logic [WIDTH-1:0]   alu_opa,
  output logic [WIDTH-1:0]   alu_opb,
  input  logic [2*WIDTH-1:0] alu_res,
  input  logic [5:0]         alu_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_res,
  output logic [5:0]         rsp_flags
);
  localparam int MAX_LAT = (MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic live, go, accept, capture, is_mul;
  // live keeps every output low until the first clock edge after reset release
  assign go        = live & en;
  assign alu_ce    = go;
  assign req_ready = go & (state == IDLE);
  assign rsp_valid = state == RESP;
  assign is_mul    = req_mode & ((req_cmd == CMD_W'(9)) | (req_cmd == CMD_W'(10)));
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        accept   = req_valid;
        state_nx = req_valid ? ISSUE : IDLE;
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        capture  = cnt == CNT_W'(1);
        state_nx = capture ? RESP : WAIT;
      end
      RESP: state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      live      <= 1'b0;
      cnt       <= '0;
      alu_inpv  <= '0;
      alu_mode  <= 1'b0;
      alu_cmd   <= '0;
      alu_cin   <= 1'b0;
      alu_opa   <= '0;
      alu_opb   <= '0;
      rsp_res   <= '0;
      rsp_flags <= '0;
    end else begin
      live <= 1'b1;
      if (go) begin
        state <= state_nx;
        if (accept) begin
          alu_inpv <= req_inpv;
          alu_mode <= req_mode;
          alu_cmd  <= req_cmd;
          alu_cin  <= req_cin;
          alu_opa  <= req_opa;
          alu_opb  <= req_opb;
          cnt      <= is_mul ? CNT_W'(MUL_LAT) : CNT_W'(BASE_LAT);
        end
        if (state == ISSUE) alu_inpv <= '0;
        if (state == WAIT) cnt <= cnt - 1'b1;
        if (capture) begin
          rsp_res   <= alu_res;
          rsp_flags <= alu_flags;
        end
      end
    end
  end
endmodule
